// File: rtl/niosii_system_cpu_mulx_seq_pkg.sv
// Shared types and constants for the multiply sequencer.
// The optional early-exit path is selected by the MULX_EARLY_EXIT_EN macro in the top.
package niosii_system_cpu_mulx_seq_pkg;

    localparam int PP_COUNT = 4;
    localparam int HALF_W   = 16;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXUU = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXSS = 2'd3
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_CORRECT = 3'd3,
        ST_DONE    = 3'd4
    } mulx_state_e;

    // Zero-extended 16-bit half of an operand (hi_sel=1 picks the upper half).
    function automatic logic [31:0] pp_operand(input logic [31:0] src, input logic hi_sel);
        logic [HALF_W-1:0] half;
        half = hi_sel ? src[31:HALF_W] : src[HALF_W-1:0];
        return {{HALF_W{1'b0}}, half};
    endfunction

endpackage

// File: rtl/niosii_system_cpu_mulx_seq_acc.sv
// 64-bit shift-accumulator for the four 16x16 partial products, plus the
// signed correction applied to the upper 32 bits for MULXSU / MULXSS.
module niosii_system_cpu_mulx_seq_acc
    import niosii_system_cpu_mulx_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        add_en_i,
    input  logic [1:0]  idx_i,
    input  logic [31:0] pp_i,
    input  mul_op_e     op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [31:0] hi_o
);

    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [63:0] pp_shifted;
    logic [31:0] corr;

    // Align the returning partial product to its weight: AL*BL <<0, cross terms <<16, AH*BH <<32.
    always_comb begin
        pp_shifted = 64'd0;
        case (idx_i)
            2'd0:    pp_shifted = {32'd0, pp_i};
            2'd1:    pp_shifted = {16'd0, pp_i, 16'd0};
            2'd2:    pp_shifted = {16'd0, pp_i, 16'd0};
            default: pp_shifted = {pp_i, 32'd0};
        endcase
    end

    // Next accumulator value; the sum wraps mod 2^64.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = 64'd0;
        end else if (add_en_i) begin
            acc_d = acc_q + pp_shifted;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= 64'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Turn the unsigned high word into a signed one: subtract B when A is negative
    // (SU, SS) and A when B is negative (SS only), mod 2^32.
    always_comb begin
        corr = 32'd0;
        if ((op_i == OP_MULXSU || op_i == OP_MULXSS) && src1_i[31]) begin
            corr = corr + src2_i;
        end
        if (op_i == OP_MULXSS && src2_i[31]) begin
            corr = corr + src1_i;
        end
        hi_o = acc_q[63:32] - corr;
    end

endmodule

// File: rtl/niosii_system_cpu_mulx_seq.sv
// Multiply sequencer in front of the 32x32->32 (low word) multiplier cell.
// MUL issues the operands once; MULX* issues four 16x16 partial products and
// returns the corrected high word. Optional feature: MULX_EARLY_EXIT_EN lets a
// MULXUU whose operands both fit in 16 bits return 0 without using the cell.
//
// Handshakes: a command transfers on the edge where cmd_valid_i && cmd_ready_o;
// a result transfers on the edge where res_valid_o && res_ready_i. res_valid_o
// and res_data_o hold steady until that edge, and cmd_valid_i is ignored while
// cmd_ready_o is low.
module niosii_system_cpu_mulx_seq
    import niosii_system_cpu_mulx_seq_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int CELL_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [DATA_W-1:0] cmd_src1_i,
    input  logic [DATA_W-1:0] cmd_src2_i,
    output logic [DATA_W-1:0] mul_src1_o,
    output logic [DATA_W-1:0] mul_src2_o,
    input  logic [DATA_W-1:0] mul_result_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic [2:0]        state_o
);

    mulx_state_e       state_q;
    mul_op_e           op_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic [1:0]        idx_q;
    logic [1:0]        idx_d;
    logic [1:0]        drain_q;
    logic              cmd_ready_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic [DATA_W-1:0] mul_src1_q;
    logic [DATA_W-1:0] mul_src2_q;

    // Tag pipe: one entry per cell pipeline stage, marking which issue returns when.
    logic              tag_v_q   [CELL_LATENCY];
    logic [1:0]        tag_idx_q [CELL_LATENCY];

    logic              accept;
    logic              early_exit;
    logic              ret_v;
    logic [1:0]        ret_idx;
    logic [31:0]       acc_hi;

    assign accept  = cmd_valid_i && cmd_ready_q;
    assign ret_v   = tag_v_q[CELL_LATENCY-1];
    assign ret_idx = tag_idx_q[CELL_LATENCY-1];
    assign idx_d   = idx_q + 2'd1;

`ifdef MULX_EARLY_EXIT_EN
    assign early_exit = (cmd_op_i == OP_MULXUU) &&
                        (cmd_src1_i[DATA_W-1:HALF_W] == '0) &&
                        (cmd_src2_i[DATA_W-1:HALF_W] == '0);
`else
    assign early_exit = 1'b0;
`endif

    // Sequencer FSM: accepts a command, drives the cell operand buses, collects the result.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            src1_q      <= '0;
            src2_q      <= '0;
            idx_q       <= 2'd0;
            drain_q     <= 2'd0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            mul_src1_q  <= '0;
            mul_src2_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q        <= mul_op_e'(cmd_op_i);
                        src1_q      <= cmd_src1_i;
                        src2_q      <= cmd_src2_i;
                        idx_q       <= 2'd0;
                        cmd_ready_q <= 1'b0;
                        if (early_exit) begin
                            state_q     <= ST_DONE;
                            res_valid_q <= 1'b1;
                            res_data_q  <= '0;
                        end else begin
                            state_q <= ST_ISSUE;
                            if (mul_op_e'(cmd_op_i) == OP_MUL) begin
                                mul_src1_q <= cmd_src1_i;
                                mul_src2_q <= cmd_src2_i;
                            end else begin
                                mul_src1_q <= pp_operand(cmd_src1_i, 1'b0);
                                mul_src2_q <= pp_operand(cmd_src2_i, 1'b0);
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (op_q == OP_MUL || idx_q == 2'(PP_COUNT - 1)) begin
                        state_q    <= ST_DRAIN;
                        drain_q    <= 2'd0;
                        mul_src1_q <= '0;
                        mul_src2_q <= '0;
                    end else begin
                        idx_q      <= idx_d;
                        mul_src1_q <= pp_operand(src1_q, idx_d[0]);
                        mul_src2_q <= pp_operand(src2_q, idx_d[1]);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 2'(CELL_LATENCY - 1)) begin
                        if (op_q == OP_MUL) begin
                            res_data_q  <= mul_result_i;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q <= ST_CORRECT;
                        end
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                ST_CORRECT: begin
                    res_data_q  <= acc_hi;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Shift the issue tag along with the cell pipeline; reset drops in-flight returns.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < CELL_LATENCY; i++) begin
                tag_v_q[i]   <= 1'b0;
                tag_idx_q[i] <= 2'd0;
            end
        end else begin
            tag_v_q[0]   <= (state_q == ST_ISSUE);
            tag_idx_q[0] <= idx_q;
            for (int i = 1; i < CELL_LATENCY; i++) begin
                tag_v_q[i]   <= tag_v_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    niosii_system_cpu_mulx_seq_acc u_acc (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (accept),
        .add_en_i (ret_v && (op_q != OP_MUL)),
        .idx_i    (ret_idx),
        .pp_i     (mul_result_i),
        .op_i     (op_q),
        .src1_i   (src1_q),
        .src2_i   (src2_q),
        .hi_o     (acc_hi)
    );

    assign cmd_ready_o = cmd_ready_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign mul_src1_o  = mul_src1_q;
    assign mul_src2_o  = mul_src2_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_niosii_system_cpu_mulx_seq.sv
// Self-checking bench for the multiply sequencer with a 1-cycle behavioural cell.
module tb_niosii_system_cpu_mulx_seq;

  localparam int L        = 1;
  localparam int MUL_LAT  = 2 + L;
  localparam int MULX_LAT = 6 + L;
`ifdef MULX_EARLY_EXIT_EN
  localparam int EE_LAT   = 1;
`else
  localparam int EE_LAT   = 6 + L;
`endif
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DONE = 3'd4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_src1;
  logic [31:0] cmd_src2;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic [31:0] mul_result;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  state_dbg;

  int          cyc;
  int          n_checks;
  int          n_err;
  logic [31:0] exp_q[$];
  int          due_q[$];
  logic        seen;

  niosii_system_cpu_mulx_seq #(.DATA_W(32), .CELL_LATENCY(L)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_src1_i   (cmd_src1),
    .cmd_src2_i   (cmd_src2),
    .mul_src1_o   (mul_src1),
    .mul_src2_o   (mul_src2),
    .mul_result_i (mul_result),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .state_o      (state_dbg)
  );

  // clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural multiplier cell: low 32 bits, one register stage
  always @(posedge clk) begin
    if (reset) mul_result <= 32'd0;
    else       mul_result <= mul_src1 * mul_src2;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: offer one command, record expected data and the cycle res_valid must rise
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int lat);
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src1  = a;
    cmd_src2  = b;
    guard     = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: got cmd_ready=0 required 1");
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(expv);
    due_q.push_back(cyc + lat);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_err++;
      $display("FAIL idle_timeout: got pending=%0d required 0", exp_q.size());
    end
  endtask

  // scoreboard monitor: compare on the first cycle of each presented result
  always @(negedge clk) begin
    if (!reset && res_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_result: got %h required none", res_data);
      end else begin
        check("res_data", res_data, exp_q.pop_front());
        check("res_latency", cyc, due_q.pop_front());
      end
    end
    if (!res_valid || res_ready) seen = 1'b0;
  end

  initial begin
    int t;
    cyc       = 0;
    n_checks  = 0;
    n_err     = 0;
    seen      = 1'b0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_src1  = 32'd0;
    cmd_src2  = 32'd0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_cmd_ready", cmd_ready, 32'd1);
    check("rst_res_valid", res_valid, 32'd0);
    check("rst_res_data",  res_data,  32'd0);
    check("rst_mul_src1",  mul_src1,  32'd0);
    check("rst_mul_src2",  mul_src2,  32'd0);
    check("rst_state",     state_dbg, S_IDLE);

    // directed vectors: op, A, B, expected, latency
    issue(2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, MUL_LAT);  wait_idle();
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT);  wait_idle();
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULX_LAT); wait_idle();
    issue(2'd1, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, EE_LAT);   wait_idle();
    issue(2'd1, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_0000, MULX_LAT); wait_idle();
    issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MULX_LAT); wait_idle();
    issue(2'd3, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, MULX_LAT); wait_idle();
    issue(2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MULX_LAT); wait_idle();
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULX_LAT); wait_idle();
    issue(2'd2, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, MULX_LAT); wait_idle();
    issue(2'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, MULX_LAT); wait_idle();

    // back-pressure: hold res_ready low in DONE while pulsing cmd_valid
    res_ready = 1'b0;
    issue(2'd1, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, MULX_LAT);
    t = 0;
    while (!res_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0] ? 1'b0 : 1'b1;
      cmd_op    = 2'd0;
      cmd_src1  = 32'd7;
      cmd_src2  = 32'd7;
      @(negedge clk);
      check("hold_res_valid", res_valid, 32'd1);
      check("hold_res_data",  res_data,  32'h0000_1234);
      check("hold_cmd_ready", cmd_ready, 32'd0);
      check("hold_state",     state_dbg, S_DONE);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();

    // reset in the middle of a MULXSS: nothing comes back from it
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_src1  = 32'hFFFF_FFFF;
    cmd_src2  = 32'h0000_0003;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_cmd_ready", cmd_ready, 32'd1);
    check("mid_rst_res_valid", res_valid, 32'd0);
    check("mid_rst_mul_src1",  mul_src1,  32'd0);
    check("mid_rst_state",     state_dbg, S_IDLE);
    issue(2'd0, 32'd3, 32'd5, 32'd15, MUL_LAT);
    wait_idle();

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
